// File: rtl/quiz_arbiter.sv
// quiz_arbiter: N-player quiz buzzer arbiter; the first synchronised key edge in an armed round wins.
// Optional feature macro FALSE_START_EN: key presses in IDLE flag and mask that player for the next round.
module quiz_arbiter #(
    parameter int unsigned N_PLAYERS   = 4,
    parameter int unsigned NUM_W       = 4,
    parameter int unsigned BLANK_CODE  = 10,
    parameter int unsigned BUZZ_CYCLES = 25_000_000
) (
    input  logic                 CLK,
    input  logic                 RSTn,
    input  logic                 Arm,
    input  logic                 Clear,
    input  logic                 Block_Sel,
    input  logic [N_PLAYERS-1:0] Keys,
    output logic [N_PLAYERS-1:0] LED_Out,
    output logic [NUM_W-1:0]     Player_Number,
    output logic                 Timer_Start,
    output logic                 Buzzer_Enable,
    output logic                 Winner_Valid,
    output logic [N_PLAYERS-1:0] False_Start
);

    localparam int unsigned      CNT_W     = $clog2(BUZZ_CYCLES + 1);
    localparam logic [NUM_W-1:0] BLANK     = NUM_W'(BLANK_CODE);
    localparam logic [CNT_W-1:0] BUZZ_LAST = CNT_W'(BUZZ_CYCLES);

    localparam logic [1:0] IDLE    = 2'd0;
    localparam logic [1:0] ARMED   = 2'd1;
    localparam logic [1:0] LOCKED  = 2'd2;
    localparam logic [1:0] TIMEOUT = 2'd3;

    logic [1:0]           state;
    logic [1:0]           state_d;
    logic [N_PLAYERS-1:0] sync1;
    logic [N_PLAYERS-1:0] sync2;
    logic [N_PLAYERS-1:0] sync3;
    logic [N_PLAYERS-1:0] key_edge;
    logic [N_PLAYERS-1:0] key_req;
    logic [N_PLAYERS-1:0] win_onehot;
    logic [N_PLAYERS-1:0] led_d;
    logic [NUM_W-1:0]     win_num;
    logic [NUM_W-1:0]     num_d;
    logic                 win_found;
    logic                 ts_d;
    logic                 wv_d;
    logic                 buzz_start;
    logic [CNT_W-1:0]     buzz_cnt;

    // Two-flop synchroniser plus one delay flop for rising-edge detection
    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            sync1 <= '0;
            sync2 <= '0;
            sync3 <= '0;
        end else begin
            sync1 <= Keys;
            sync2 <= sync1;
            sync3 <= sync2;
        end
    end

    assign key_edge = sync2 & ~sync3;

`ifdef FALSE_START_EN
    logic [N_PLAYERS-1:0] fs_q;
    logic [N_PLAYERS-1:0] fs_d;

    assign key_req     = key_edge & ~fs_q;
    assign False_Start = fs_q;

    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            fs_q <= '0;
        end else begin
            fs_q <= fs_d;
        end
    end

    // Flags accumulate only in IDLE and are dropped by Clear
    always_comb begin
        fs_d = fs_q;
        if (Clear) begin
            fs_d = '0;
        end else if (state == IDLE) begin
            fs_d = fs_q | key_edge;
        end
    end
`else
    assign key_req     = key_edge;
    assign False_Start = '0;
`endif

    // Lowest-index requesting player wins simultaneous edges
    always_comb begin
        win_onehot = '0;
        win_num    = BLANK;
        win_found  = 1'b0;
        for (int unsigned i = 0; i < N_PLAYERS; i++) begin
            if (key_req[i] && !win_found) begin
                win_found     = 1'b1;
                win_onehot[i] = 1'b1;
                win_num       = NUM_W'(i + 1);
            end
        end
    end

    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            state <= IDLE;
        end else begin
            state <= state_d;
        end
    end

    always_comb begin
        state_d    = state;
        led_d      = LED_Out;
        num_d      = Player_Number;
        ts_d       = Timer_Start;
        wv_d       = Winner_Valid;
        buzz_start = 1'b0;
        if (Clear) begin
            state_d = IDLE;
            led_d   = '0;
            num_d   = BLANK;
            ts_d    = 1'b0;
            wv_d    = 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (Arm) begin
                        state_d = ARMED;
                        ts_d    = 1'b1;
                        led_d   = '0;
                        num_d   = BLANK;
                    end
                end
                ARMED: begin
                    // A key edge beats a simultaneous timer expiry
                    if (win_found) begin
                        state_d    = LOCKED;
                        led_d      = win_onehot;
                        num_d      = win_num;
                        wv_d       = 1'b1;
                        ts_d       = 1'b0;
                        buzz_start = 1'b1;
                    end else if (Block_Sel) begin
                        state_d    = TIMEOUT;
                        ts_d       = 1'b0;
                        buzz_start = 1'b1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            LED_Out       <= '0;
            Player_Number <= BLANK;
            Timer_Start   <= 1'b0;
            Winner_Valid  <= 1'b0;
        end else begin
            LED_Out       <= led_d;
            Player_Number <= num_d;
            Timer_Start   <= ts_d;
            Winner_Valid  <= wv_d;
        end
    end

    // Buzzer: counter holds the number of high cycles issued, saturating at the pulse length
    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            Buzzer_Enable <= 1'b0;
            buzz_cnt      <= '0;
        end else if (Clear) begin
            Buzzer_Enable <= 1'b0;
            buzz_cnt      <= '0;
        end else if (buzz_start) begin
            Buzzer_Enable <= 1'b1;
            buzz_cnt      <= CNT_W'(1);
        end else if (Buzzer_Enable) begin
            if (buzz_cnt == BUZZ_LAST) begin
                Buzzer_Enable <= 1'b0;
            end else begin
                buzz_cnt <= buzz_cnt + CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_quiz_arbiter.sv
// tb_quiz_arbiter: directed and random stimulus against a round-level reference model of quiz_arbiter.
// Expected False_Start behaviour follows the FALSE_START_EN macro of the build.
module tb_quiz_arbiter;

    localparam int unsigned NP    = 4;
    localparam int unsigned NW    = 4;
    localparam int unsigned BLANK = 10;
    localparam int unsigned BUZZ  = 8;

    logic          CLK = 1'b0;
    logic          RSTn;
    logic          Arm;
    logic          Clear;
    logic          Block_Sel;
    logic [NP-1:0] Keys;
    logic [NP-1:0] LED_Out;
    logic [NW-1:0] Player_Number;
    logic          Timer_Start;
    logic          Buzzer_Enable;
    logic          Winner_Valid;
    logic [NP-1:0] False_Start;

    quiz_arbiter #(
        .N_PLAYERS  (NP),
        .NUM_W      (NW),
        .BLANK_CODE (BLANK),
        .BUZZ_CYCLES(BUZZ)
    ) dut (
        .CLK          (CLK),
        .RSTn         (RSTn),
        .Arm          (Arm),
        .Clear        (Clear),
        .Block_Sel    (Block_Sel),
        .Keys         (Keys),
        .LED_Out      (LED_Out),
        .Player_Number(Player_Number),
        .Timer_Start  (Timer_Start),
        .Buzzer_Enable(Buzzer_Enable),
        .Winner_Valid (Winner_Valid),
        .False_Start  (False_Start)
    );

    always #5 CLK = ~CLK;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Reference model: round phase, key samples seen at past edges, remaining buzzer cycles
    typedef enum {PH_IDLE, PH_OPEN, PH_WON, PH_EXPIRED} phase_t;
    phase_t        ph;
    logic [NP-1:0] samples[$];
    int            buzz_left;
    logic [NP-1:0] e_led;
    logic [NW-1:0] e_num;
    logic          e_ts;
    logic          e_wv;
    logic [NP-1:0] e_fs;

    task automatic model_reset();
        ph        = PH_IDLE;
        samples   = '{'0, '0, '0};
        buzz_left = 0;
        e_led     = '0;
        e_num     = NW'(BLANK);
        e_ts      = 1'b0;
        e_wv      = 1'b0;
        e_fs      = '0;
    endtask

    // A press sampled at edge k-2 (and absent at k-3) is acted on at edge k
    task automatic model_step();
        logic [NP-1:0] rises;
        logic [NP-1:0] cand;
        int            w;
        rises = samples[1] & ~samples[2];
        if (buzz_left > 0) buzz_left--;
        if (Clear) begin
            ph        = PH_IDLE;
            e_led     = '0;
            e_num     = NW'(BLANK);
            e_ts      = 1'b0;
            e_wv      = 1'b0;
            buzz_left = 0;
            e_fs      = '0;
        end else begin
            case (ph)
                PH_IDLE: begin
`ifdef FALSE_START_EN
                    e_fs = e_fs | rises;
`endif
                    if (Arm) begin
                        ph    = PH_OPEN;
                        e_ts  = 1'b1;
                        e_led = '0;
                        e_num = NW'(BLANK);
                    end
                end
                PH_OPEN: begin
                    cand = rises & ~e_fs;
                    w    = -1;
                    for (int i = NP - 1; i >= 0; i--) begin
                        if (cand[i]) w = i;
                    end
                    if (w >= 0) begin
                        ph        = PH_WON;
                        e_led     = NP'(1) << w;
                        e_num     = NW'(w + 1);
                        e_wv      = 1'b1;
                        e_ts      = 1'b0;
                        buzz_left = BUZZ;
                    end else if (Block_Sel) begin
                        ph        = PH_EXPIRED;
                        e_ts      = 1'b0;
                        buzz_left = BUZZ;
                    end
                end
                default: begin
                end
            endcase
        end
        void'(samples.pop_back());
        samples.push_front(Keys);
    endtask

    task automatic compare_all();
        chk_eq("led", 32'(LED_Out), 32'(e_led));
        chk_eq("num", 32'(Player_Number), 32'(e_num));
        chk_eq("timer_start", 32'(Timer_Start), 32'(e_ts));
        chk_eq("buzzer", 32'(Buzzer_Enable), 32'(buzz_left > 0));
        chk_eq("winner_valid", 32'(Winner_Valid), 32'(e_wv));
        chk_eq("false_start", 32'(False_Start), 32'(e_fs));
    endtask

    task automatic tick();
        @(posedge CLK);
        if (!RSTn) model_reset();
        else model_step();
        #1;
        compare_all();
    endtask

    task automatic async_reset();
        RSTn = 1'b0;
        #1;
        model_reset();
        compare_all();
        chk_eq("async_rst_buzz", 32'(Buzzer_Enable), 32'd0);
        tick();
        RSTn = 1'b1;
    endtask

    task automatic arm_round();
        Arm = 1'b1;
        tick();
        Arm = 1'b0;
    endtask

    task automatic clear_round();
        Clear = 1'b1;
        tick();
        Clear = 1'b0;
    endtask

    int buzz_high;

    initial begin
        RSTn      = 1'b0;
        Arm       = 1'b0;
        Clear     = 1'b0;
        Block_Sel = 1'b0;
        Keys      = '0;
        model_reset();
        tick();
        tick();
        RSTn = 1'b1;
        tick();
        chk_eq("rst_num", 32'(Player_Number), 32'd10);

        // Arm, then a single winner with latency and buzzer length checks
        arm_round();
        chk_eq("arm_ts", 32'(Timer_Start), 32'd1);
        chk_eq("arm_num", 32'(Player_Number), 32'd10);
        chk_eq("arm_led", 32'(LED_Out), 32'd0);
        chk_eq("arm_buzz", 32'(Buzzer_Enable), 32'd0);
        Keys = 4'b0100;
        tick();
        Keys = '0;
        tick();
        chk_eq("latency_early", 32'(Winner_Valid), 32'd0);
        tick();
        chk_eq("win_led", 32'(LED_Out), 32'b0100);
        chk_eq("win_num", 32'(Player_Number), 32'd3);
        chk_eq("win_valid", 32'(Winner_Valid), 32'd1);
        chk_eq("win_ts", 32'(Timer_Start), 32'd0);
        buzz_high = int'(Buzzer_Enable);
        repeat (12) begin
            tick();
            if (Buzzer_Enable) buzz_high++;
        end
        chk_eq("buzz_len", 32'(buzz_high), 32'd8);
        clear_round();

        // Simultaneous edges: lowest index wins, later presses ignored
        arm_round();
        Keys = 4'b1010;
        tick();
        Keys = '0;
        repeat (3) tick();
        chk_eq("simul_num", 32'(Player_Number), 32'd2);
        chk_eq("simul_led", 32'(LED_Out), 32'b0010);
        Keys = 4'b0001;
        tick();
        Keys = '0;
        repeat (5) tick();
        chk_eq("locked_num", 32'(Player_Number), 32'd2);
        chk_eq("locked_led", 32'(LED_Out), 32'b0010);
        clear_round();

        // Timeout with no key, later keys ignored
        arm_round();
        Block_Sel = 1'b1;
        tick();
        Block_Sel = 1'b0;
        chk_eq("to_ts", 32'(Timer_Start), 32'd0);
        chk_eq("to_num", 32'(Player_Number), 32'd10);
        chk_eq("to_buzz", 32'(Buzzer_Enable), 32'd1);
        Keys = 4'b0001;
        tick();
        Keys = '0;
        repeat (5) tick();
        chk_eq("to_keys_num", 32'(Player_Number), 32'd10);
        chk_eq("to_keys_wv", 32'(Winner_Valid), 32'd0);
        clear_round();

        // Key held through arming must be released and re-pressed
        Keys = 4'b0001;
        repeat (4) tick();
        arm_round();
        repeat (5) tick();
        chk_eq("held_wv", 32'(Winner_Valid), 32'd0);
`ifdef FALSE_START_EN
        chk_eq("fs_flag", 32'(False_Start), 32'b0001);
`endif
        Keys = '0;
        repeat (2) tick();
        Keys = 4'b0001;
        repeat (4) tick();
`ifdef FALSE_START_EN
        chk_eq("repress_wv", 32'(Winner_Valid), 32'd0);
`else
        chk_eq("repress_num", 32'(Player_Number), 32'd1);
`endif
        Keys = '0;
        clear_round();

        // Clear while buzzer active
        arm_round();
        Keys = 4'b0010;
        tick();
        Keys = '0;
        repeat (4) tick();
        clear_round();
        chk_eq("clr_led", 32'(LED_Out), 32'd0);
        chk_eq("clr_num", 32'(Player_Number), 32'd10);
        chk_eq("clr_buzz", 32'(Buzzer_Enable), 32'd0);
        chk_eq("clr_wv", 32'(Winner_Valid), 32'd0);

        // Asynchronous reset mid-buzzer
        arm_round();
        Keys = 4'b1000;
        tick();
        Keys = '0;
        repeat (4) tick();
        async_reset();
        chk_eq("arst_num", 32'(Player_Number), 32'd10);

        // Random traffic against the model
        for (int c = 0; c < 2500; c++) begin
            Arm       = ($urandom_range(0, 15) == 0);
            Clear     = ($urandom_range(0, 39) == 0);
            Block_Sel = ($urandom_range(0, 24) == 0);
            if ($urandom_range(0, 3) == 0) Keys = NP'($urandom);
            if ($urandom_range(0, 499) == 0) async_reset();
            tick();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
